// File: rtl/audio_peak_meter_pkg.sv
// Shared definitions for the audio peak meter.
// Holds the default word sizes, the 48 kHz timing defaults, the bar width
// and the envelope phase type used by the top level.
package audio_peak_meter_pkg;

  // Magnitude word size and fixed-point fraction position of the upstream path.
  localparam int unsigned DEF_WS = 16;
  localparam int unsigned DP     = 8;

  // Defaults for a 48 kHz sample rate.
  localparam int unsigned DEF_HOLD        = 4800;   // 100 ms peak hold
  localparam int unsigned DEF_DECAY_SHIFT = 10;
  localparam int unsigned DEF_CLIP_TH     = 32000;
  localparam int unsigned DEF_CLIP_HOLD   = 24000;  // 500 ms clip indication
  localparam int unsigned DEF_WIN         = 800;    // 60 display frames/s

  localparam int unsigned BAR_W = 4;

  // Which rule updates the envelope on a given sample.
  typedef enum logic [1:0] {
    ENV_ATTACK,
    ENV_HOLD,
    ENV_DECAY
  } env_phase_e;

endpackage

// File: rtl/audio_peak_meter_peak_to_bar.sv
// peak_to_bar: combinational priority encoder.
// Ports:
//   val - envelope value, WS-1 bits, unsigned
//   bar - index of the highest set bit plus one; 0 when val == 0
module peak_to_bar
  import audio_peak_meter_pkg::*;
#(
  parameter int unsigned WS = DEF_WS
) (
  input  logic [WS-2:0]    val,
  output logic [BAR_W-1:0] bar
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    bar = '0;
    for (int unsigned i = 0; i < WS - 1; i++) begin
      if (val[i]) begin
        bar = BAR_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/audio_peak_meter.sv
// audio_peak_meter: VU-meter front end for the magnitude stream.
// Produces a peak-hold/decay envelope, a log2 bar level, a clip indicator
// and a per-window maximum for the display refresh.
// Ports:
//   clk, rst_n         - system clock, synchronous active-low reset
//   in_valid, in_mag   - sample strobe and signed magnitude (negatives read as 0)
//   clr                - synchronous clear of all state, overrides in_valid
//   peak, bar, clip    - envelope, bar level, clip flag (valid with out_valid)
//   out_valid          - pulses one cycle after an accepted sample
//   win_peak, win_stb  - maximum of the last completed window and its strobe
module audio_peak_meter
  import audio_peak_meter_pkg::*;
#(
  parameter int unsigned WS          = DEF_WS,
  parameter int unsigned HOLD        = DEF_HOLD,
  parameter int unsigned DECAY_SHIFT = DEF_DECAY_SHIFT,
  parameter int unsigned CLIP_TH     = DEF_CLIP_TH,
  parameter int unsigned CLIP_HOLD   = DEF_CLIP_HOLD,
  parameter int unsigned WIN         = DEF_WIN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [WS-1:0] in_mag,
  input  logic                 clr,
  output logic [WS-1:0]        peak,
  output logic [BAR_W-1:0]     bar,
  output logic                 clip,
  output logic                 out_valid,
  output logic [WS-1:0]        win_peak,
  output logic                 win_stb
);

  localparam int unsigned MW     = WS - 1;
  localparam int unsigned HOLD_W = $clog2(HOLD + 1);
  localparam int unsigned CLIP_W = $clog2(CLIP_HOLD + 1);
  localparam int unsigned WIN_W  = $clog2(WIN + 1);

  localparam logic [HOLD_W-1:0] HOLD_V      = HOLD_W'(HOLD);
  localparam logic [CLIP_W-1:0] CLIP_HOLD_V = CLIP_W'(CLIP_HOLD);
  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WIN - 1);
  localparam logic [MW-1:0]     CLIP_TH_V   = MW'(CLIP_TH);

  logic [MW-1:0]     mag;
  logic [MW-1:0]     peak_r;
  logic [MW-1:0]     peak_nxt;
  logic [MW-1:0]     decay_step;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [CLIP_W-1:0] clip_cnt;
  logic [CLIP_W-1:0] clip_cnt_nxt;
  logic              clip_nxt;
  logic [WIN_W-1:0]  win_cnt;
  logic [MW-1:0]     win_acc;
  logic [MW-1:0]     win_max;
  logic [MW-1:0]     win_peak_r;
  logic [BAR_W-1:0]  bar_nxt;
  env_phase_e        phase;

  // Envelope, clip and window next-state decode.
  always_comb begin
    mag = in_mag[WS-1] ? '0 : in_mag[MW-1:0];

    if (mag >= peak_r) begin
      phase = ENV_ATTACK;
    end else if (hold_cnt != '0) begin
      phase = ENV_HOLD;
    end else begin
      phase = ENV_DECAY;
    end

    // Minimum step of 1 so small envelopes still reach zero; step <= peak_r
    // always holds, so the subtraction cannot underflow.
    decay_step = peak_r >> DECAY_SHIFT;
    if (decay_step == '0 && peak_r != '0) begin
      decay_step = MW'(1);
    end

    peak_nxt = peak_r;
    hold_nxt = hold_cnt;
    case (phase)
      ENV_ATTACK: begin
        peak_nxt = mag;
        hold_nxt = HOLD_V;
      end
      ENV_HOLD: begin
        hold_nxt = hold_cnt - HOLD_W'(1);
      end
      ENV_DECAY: begin
        peak_nxt = peak_r - decay_step;
      end
      default: begin
        peak_nxt = peak_r;
        hold_nxt = hold_cnt;
      end
    endcase

    clip_cnt_nxt = clip_cnt;
    clip_nxt     = clip;
    if (mag >= CLIP_TH_V) begin
      clip_cnt_nxt = CLIP_HOLD_V;
      clip_nxt     = 1'b1;
    end else if (clip_cnt != '0) begin
      clip_cnt_nxt = clip_cnt - CLIP_W'(1);
      clip_nxt     = (clip_cnt_nxt != '0);
    end

    win_max = (mag > win_acc) ? mag : win_acc;
  end

  // Bar level follows the new envelope in the same register stage.
  peak_to_bar #(
    .WS(WS)
  ) u_peak_to_bar (
    .val(peak_nxt),
    .bar(bar_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      peak_r     <= '0;
      hold_cnt   <= '0;
      bar        <= '0;
      clip_cnt   <= '0;
      clip       <= 1'b0;
      win_cnt    <= '0;
      win_acc    <= '0;
      win_peak_r <= '0;
      win_stb    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      win_stb   <= 1'b0;
      if (in_valid) begin
        peak_r   <= peak_nxt;
        hold_cnt <= hold_nxt;
        bar      <= bar_nxt;
        clip_cnt <= clip_cnt_nxt;
        clip     <= clip_nxt;
        // The sample at WIN-1 closes its own window.
        if (win_cnt == WIN_LAST) begin
          win_peak_r <= win_max;
          win_stb    <= 1'b1;
          win_acc    <= '0;
          win_cnt    <= '0;
        end else begin
          win_acc <= win_max;
          win_cnt <= win_cnt + WIN_W'(1);
        end
      end
    end
  end

  assign peak     = {1'b0, peak_r};
  assign win_peak = {1'b0, win_peak_r};

endmodule

// File: tb/tb_audio_peak_meter.sv
// Self-checking bench for audio_peak_meter with short timing parameters.
module tb_audio_peak_meter;

  localparam int HOLD  = 4;
  localparam int DS    = 2;
  localparam int CTH   = 32000;
  localparam int CHOLD = 3;
  localparam int WIN   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] in_mag;
  logic               clr;
  logic [15:0]        peak;
  logic [3:0]         bar;
  logic               clip;
  logic               out_valid;
  logic [15:0]        win_peak;
  logic               win_stb;

  always #5 clk = ~clk;

  audio_peak_meter #(
    .WS(16),
    .HOLD(HOLD),
    .DECAY_SHIFT(DS),
    .CLIP_TH(CTH),
    .CLIP_HOLD(CHOLD),
    .WIN(WIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_mag(in_mag),
    .clr(clr),
    .peak(peak),
    .bar(bar),
    .clip(clip),
    .out_valid(out_valid),
    .win_peak(win_peak),
    .win_stb(win_stb)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int mp, mh, mcl, mwp;
  bit mclip, mov, mstb;
  int mq[$];

  typedef struct {
    bit r;
    bit v;
    int mag;
    bit c;
    int pk;
    int br;
    bit cl;
    bit ov;
  } vec_t;
  vec_t tbl[$];

  function automatic int nbits(input int x);
    int n = 0;
    while (x > 0) begin
      n++;
      x = x >> 1;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_upd(input bit r, input bit v, input int mag, input bit c);
    int m, d, mx;
    if (!r || c) begin
      mp = 0; mh = 0; mcl = 0; mclip = 0; mwp = 0; mov = 0; mstb = 0;
      mq.delete();
    end else if (!v) begin
      mov = 0; mstb = 0;
    end else begin
      m = (mag < 0) ? 0 : mag;
      if (m >= mp) begin
        mp = m; mh = HOLD;
      end else if (mh > 0) begin
        mh--;
      end else begin
        d = mp / (1 << DS);
        if (d == 0 && mp > 0) d = 1;
        mp = mp - d;
        if (mp < 0) mp = 0;
      end
      if (m >= CTH) begin
        mcl = CHOLD; mclip = 1;
      end else if (mcl > 0) begin
        mcl--; mclip = (mcl != 0);
      end
      mq.push_back(m);
      mstb = 0;
      if (mq.size() == WIN) begin
        mx = 0;
        foreach (mq[i]) if (mq[i] > mx) mx = mq[i];
        mwp = mx; mstb = 1;
        mq.delete();
      end
      mov = 1;
    end
  endtask

  task automatic step(input bit r, input bit v, input int mag, input bit c);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    in_mag   = mag[15:0];
    clr      = c;
    model_upd(r, v, mag, c);
    @(posedge clk);
    #1;
    chk("peak", int'(peak), mp);
    chk("bar", int'(bar), nbits(mp));
    chk("clip", int'(clip), int'(mclip));
    chk("out_valid", int'(out_valid), int'(mov));
    chk("win_peak", int'(win_peak), mwp);
    chk("win_stb", int'(win_stb), int'(mstb));
  endtask

  function automatic void add(input bit r, v, input int mag, input bit c,
                              input int pk, br, input bit cl, ov);
    vec_t e;
    e.r = r; e.v = v; e.mag = mag; e.c = c;
    e.pk = pk; e.br = br; e.cl = cl; e.ov = ov;
    tbl.push_back(e);
  endfunction

  initial begin
    int r, mag;
    bit v, c, rr;
    rst_n = 1'b0; in_valid = 1'b0; in_mag = '0; clr = 1'b0;
    mp = 0; mh = 0; mcl = 0; mwp = 0; mclip = 0; mov = 0; mstb = 0;

    // Reset with in_valid toggling, then attack/hold/decay.
    add(0, 1, 1000, 0,     0,  0, 0, 0);
    add(0, 0,    0, 0,     0,  0, 0, 0);
    add(0, 1,  500, 0,     0,  0, 0, 0);
    add(1, 1, 1000, 0,  1000, 10, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1000, 10, 0, 1);
    add(1, 1,    0, 0,   750, 10, 0, 1);
    add(1, 1,    0, 0,   563, 10, 0, 1);
    add(1, 1,    0, 0,   423,  9, 0, 1);
    add(1, 1,    0, 0,   318,  9, 0, 1);
    add(1, 0,    0, 0,   318,  9, 0, 0);
    // Negative and full-scale input, clip hold.
    add(1, 0,    0, 1,     0,  0, 0, 0);
    add(1, 1,   -5, 0,     0,  0, 0, 1);
    add(1, 1, 32767, 0, 32767, 15, 1, 1);
    add(1, 1,    0, 0, 32767, 15, 1, 1);
    add(1, 1,    0, 0, 32767, 15, 1, 1);
    add(1, 1,    0, 0, 32767, 15, 0, 1);
    // clr beats a simultaneous sample.
    add(1, 1,  500, 1,     0,  0, 0, 0);
    add(1, 1,   20, 0,    20,  5, 0, 1);
    // Re-attack in the middle of hold restarts the hold.
    add(1, 1, 1000, 0,  1000, 10, 0, 1);
    add(1, 1,    0, 0,  1000, 10, 0, 1);
    add(1, 1,    0, 0,  1000, 10, 0, 1);
    add(1, 1, 1200, 0,  1200, 11, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1200, 11, 0, 1);
    add(1, 1,    0, 0,   900, 10, 0, 1);

    step(0, 0, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].mag, tbl[i].c);
      chk($sformatf("tbl%0d.peak", i), int'(peak), tbl[i].pk);
      chk($sformatf("tbl%0d.bar", i), int'(bar), tbl[i].br);
      chk($sformatf("tbl%0d.clip", i), int'(clip), int'(tbl[i].cl));
      chk($sformatf("tbl%0d.ov", i), int'(out_valid), int'(tbl[i].ov));
    end

    // Decay tail: from 3 the envelope steps 2, 1, 0 and stays at 0.
    step(1, 0, 0, 1);
    step(1, 1, 1000, 0);
    for (int i = 0; i < 100 && mp != 3; i++) step(1, 1, 0, 0);
    chk("decay_reach3", int'(peak), 3);
    step(1, 1, 0, 0); chk("tail2", int'(peak), 2); chk("tail2.bar", int'(bar), 2);
    step(1, 1, 0, 0); chk("tail1", int'(peak), 1); chk("tail1.bar", int'(bar), 1);
    step(1, 1, 0, 0); chk("tail0", int'(peak), 0); chk("tail0.bar", int'(bar), 0);
    step(1, 1, 0, 0); chk("tail0b", int'(peak), 0);

    // Window: maximum of 3,9,2,7,1,0,4,5 is 9, then an all-zero window.
    step(1, 0, 0, 1);
    begin
      int w[8] = '{3, 9, 2, 7, 1, 0, 4, 5};
      for (int i = 0; i < 8; i++) begin
        step(1, 1, w[i], 0);
        chk($sformatf("win1.stb%0d", i), int'(win_stb), (i == 7) ? 1 : 0);
      end
      chk("win1.peak", int'(win_peak), 9);
      for (int i = 0; i < 8; i++) begin
        step(1, 1, 0, 0);
        chk($sformatf("win2.stb%0d", i), int'(win_stb), (i == 7) ? 1 : 0);
        if (i < 7) chk($sformatf("win2.hold%0d", i), int'(win_peak), 9);
      end
      chk("win2.peak", int'(win_peak), 0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(3) != 0);
      c  = ($urandom_range(63) == 0);
      rr = ($urandom_range(199) != 0);
      r  = $urandom_range(9);
      if (r < 4)       mag = $urandom_range(300);
      else if (r < 6)  mag = $urandom_range(32767, 31900);
      else if (r < 7)  mag = -int'($urandom_range(32768, 1));
      else             mag = $urandom_range(32767);
      step(rr, v, mag, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
